mem_arbiter: RTL

//  Two-requester arbiter/sequencer in front of one shared byte-addressed memory port (single access per slot).

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_starve_prio.sv | 39 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF  = 32;
  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned MAX_DATA_BURST_DEF = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/arb_starve_prio.sv
// Grant decision between fetch and data: data has priority unless fetch has
// waited through MAX_DATA_BURST consecutive data grants.
module arb_starve_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_accept,
  input  logic i_if_valid,
  input  logic i_d_valid,
  output logic o_grant_if,
  output logic o_grant_d
);

  localparam int unsigned CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_BURST);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;

  always_comb begin
    w_starved  = (r_starve_cnt == MAX_CNT) && i_if_valid;
    o_grant_d  = i_accept && i_d_valid && !w_starved;
    o_grant_if = i_accept && i_if_valid && !o_grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_if_valid || o_grant_if) begin
      r_starve_cnt <= '0;
    end else if (o_grant_d && (r_starve_cnt != MAX_CNT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) sequencer in front of one shared memory port.
// One access per IDLE/RESP -> ISSUE -> RESP slot; response two cycles after accept.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_rsp_valid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_rsp_valid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t               r_state;
  arb_owner_t               r_owner;
  logic                     r_run;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_we;
  logic [BE_WIDTH-1:0]      r_be;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_mem_en;
  logic                     r_mem_we;
  logic                     r_if_rsp;
  logic                     r_d_rsp;
  logic [DATA_WIDTH-1:0]    r_if_rdata;
  logic [DATA_WIDTH-1:0]    r_d_rdata;

  logic                     w_accept;
  logic                     w_grant_if;
  logic                     w_grant_d;
  logic                     w_hs;
  logic [DATA_WIDTH-1:0]    w_d_rsp_data;

  // r_run keeps both readys low while reset is held and for one edge after release.
  always_comb begin
    w_accept     = r_run && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    w_hs         = w_grant_if || w_grant_d;
    w_d_rsp_data = r_we ? '0 : mem_rdata;
  end

  arb_starve_prio #(
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_accept   (w_accept),
    .i_if_valid (if_req_valid),
    .i_d_valid  (d_req_valid),
    .o_grant_if (w_grant_if),
    .o_grant_d  (w_grant_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_run      <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_rsp   <= 1'b0;
      r_d_rsp    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_run    <= 1'b1;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_if_rsp <= 1'b0;
      r_d_rsp  <= 1'b0;
      if (r_if_rsp) r_if_rdata <= mem_rdata;
      if (r_d_rsp)  r_d_rdata  <= w_d_rsp_data;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_hs) begin
            r_state  <= ST_ISSUE;
            r_owner  <= w_grant_d ? OWN_D : OWN_IF;
            r_addr   <= w_grant_d ? d_addr : if_addr;
            r_we     <= w_grant_d && d_we;
            r_be     <= w_grant_d ? d_be : '1;
            r_wdata  <= w_grant_d ? d_wdata : '0;
            r_mem_en <= 1'b1;
            r_mem_we <= w_grant_d && d_we;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_state  <= ST_RESP;
          r_if_rsp <= (r_owner == OWN_IF);
          r_d_rsp  <= (r_owner == OWN_D);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data arrives during RESP, so the response path bypasses the hold registers.
  always_comb begin
    if_req_ready = w_grant_if;
    d_req_ready  = w_grant_d;
    if_rsp_valid = r_if_rsp;
    d_rsp_valid  = r_d_rsp;
    if_rdata     = r_if_rsp ? mem_rdata : r_if_rdata;
    d_rdata      = r_d_rsp ? w_d_rsp_data : r_d_rdata;
    mem_en       = r_mem_en;
    mem_we       = r_mem_we;
    mem_be       = r_be;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
  end

endmodule
